mux_nch_scan: RTL and testbench

- Parametrised, registered N-channel, W-bit multiplexer. It is the sequential successor to the fixed 16:1 combinational mux.
- Two modes:
  - Manual: the `sel` input picks the channel.
  - Auto-scan: a round-robin sequencer steps through the enabled channels, with a programmable dwell between samples.
- The output carries a valid/ready handshake, so a downstream consumer can stall the block.
- Typical use: sampling front end feeding a serialiser or logger.

---
 rtl/mux_nch_scan.sv | 135 +++++++++++++
 tb/tb_mux_nch_scan.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nch_scan.sv
// Registered N-channel mux with manual select or round-robin auto-scan,
// presenting each captured sample on a valid/ready output port.
module mux_nch_scan #(
    parameter int NUM_CH  = 16,
    parameter int DATA_W  = 8,
    parameter int DWELL_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*DATA_W-1:0]    datain,
    input  logic                        mode,
    input  logic [$clog2(NUM_CH)-1:0]   sel,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic [DWELL_W-1:0]          dwell,
    output logic [DATA_W-1:0]           y_data,
    output logic [$clog2(NUM_CH)-1:0]   y_ch,
    output logic                        y_valid,
    input  logic                        y_ready,
    output logic                        scan_wrap
);

    localparam int SEL_W = $clog2(NUM_CH);

    typedef enum logic {
        SCAN_WAIT,
        SCAN_SAMPLE
    } scan_state_t;

    logic [SEL_W-1:0]   ptr;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               mode_q;

    logic               open;
    logic               scan_entry;
    logic [SEL_W-1:0]   ptr_eff;
    logic [DWELL_W-1:0] cnt_eff;
    scan_state_t        scan_state;
    logic               found;
    logic [SEL_W-1:0]   scan_ch;
    logic [SEL_W-1:0]   low_ch;
    logic [SEL_W-1:0]   ptr_next;
    logic               capture;
    logic [SEL_W-1:0]   cap_ch;
    logic [DATA_W-1:0]  cap_data;

    // The first scan-mode cycle after manual operation restarts the scan from channel 0 with no dwell.
    assign open       = !y_valid || y_ready;
    assign scan_entry = mode && !mode_q;
    assign ptr_eff    = scan_entry ? '0 : ptr;
    assign cnt_eff    = scan_entry ? '0 : dwell_cnt;
    assign scan_state = (cnt_eff == '0) ? SCAN_SAMPLE : SCAN_WAIT;

    always_comb begin
        int               idx;
        logic [SEL_W-1:0] cand;
        found   = 1'b0;
        scan_ch = '0;
        idx     = 0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr_eff) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            cand = SEL_W'(idx);
            if (!found && ch_en[cand]) begin
                found   = 1'b1;
                scan_ch = cand;
            end
        end
    end

    always_comb begin
        low_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                low_ch = SEL_W'(i);
            end
        end
    end

    assign ptr_next = (int'(scan_ch) == NUM_CH - 1) ? '0 : scan_ch + 1'b1;
    assign capture  = mode ? (scan_state == SCAN_SAMPLE && open && found) : open;
    assign cap_ch   = mode ? scan_ch : sel;

    // An out-of-range manual select matches no channel and captures zero.
    always_comb begin
        cap_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cap_ch == SEL_W'(k)) begin
                cap_data = datain[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_data    <= '0;
            y_ch      <= '0;
            y_valid   <= 1'b0;
            scan_wrap <= 1'b0;
            ptr       <= '0;
            dwell_cnt <= '0;
            mode_q    <= 1'b0;
        end else begin
            mode_q    <= mode;
            scan_wrap <= capture && mode && (scan_ch == low_ch);

            if (capture) begin
                y_data  <= cap_data;
                y_ch    <= cap_ch;
                y_valid <= 1'b1;
            end else if (open) begin
                y_valid <= 1'b0;
            end

            // Dwell counts down even while the output is stalled.
            if (mode) begin
                if (scan_state == SCAN_WAIT) begin
                    dwell_cnt <= cnt_eff - 1'b1;
                    ptr       <= ptr_eff;
                end else if (capture) begin
                    dwell_cnt <= dwell;
                    ptr       <= ptr_next;
                end else begin
                    dwell_cnt <= cnt_eff;
                    ptr       <= ptr_eff;
                end
            end else begin
                dwell_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nch_scan.sv
// Directed bench for mux_nch_scan: expected words are queued at stimulus time
// and a negedge monitor checks each accepted output word against the queue.
module tb_mux_nch_scan;

    logic           clk;
    logic           rst_n;
    logic [127:0]   datain;
    logic           mode;
    logic [3:0]     sel;
    logic [15:0]    ch_en;
    logic [7:0]     dwell;
    logic [7:0]     y_data;
    logic [3:0]     y_ch;
    logic           y_valid;
    logic           y_ready;
    logic           scan_wrap;

    typedef struct {
        logic [7:0] data;
        logic [3:0] ch;
        logic       wrap;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   last_acc   = -100;
    logic prev_stalled = 1'b0;

    mux_nch_scan #(.NUM_CH(16), .DATA_W(8), .DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .datain    (datain),
        .mode      (mode),
        .sel       (sel),
        .ch_en     (ch_en),
        .dwell     (dwell),
        .y_data    (y_data),
        .y_ch      (y_ch),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .scan_wrap (scan_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] data, input logic [3:0] ch, input logic wrap, input int gap);
        exp_t e;
        e.data = data;
        e.ch   = ch;
        e.wrap = wrap;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A word held over a stalled edge has had its wrap pulse cleared by then.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n && y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_word", {20'd0, y_ch, y_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_output("mon_data", 32'(y_data), 32'(e.data));
                check_output("mon_ch", 32'(y_ch), 32'(e.ch));
                check_output("mon_wrap", 32'(scan_wrap), prev_stalled ? 32'd0 : 32'(e.wrap));
                if (e.gap >= 0) begin
                    check_output("mon_gap", 32'(cyc - last_acc), 32'(e.gap));
                end
            end
            last_acc = cyc;
        end
        prev_stalled = y_valid && !y_ready;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            datain[k*8 +: 8] = 8'(8'h10 + k);
        end
        rst_n   = 1'b1;
        mode    = 1'b1;
        sel     = 4'd0;
        ch_en   = 16'h0000;
        dwell   = 8'd0;
        y_ready = 1'b0;

        #2 rst_n = 1'b0;
        #2;
        check_output("rst_valid", 32'(y_valid), 32'd0);
        check_output("rst_data", 32'(y_data), 32'd0);
        check_output("rst_ch", 32'(y_ch), 32'd0);
        check_output("rst_wrap", 32'(scan_wrap), 32'd0);
        apply_stimulus(2);
        rst_n = 1'b1;
        apply_stimulus(2);
        check_output("idle_valid", 32'(y_valid), 32'd0);

        // Manual select tracks sel one cycle late.
        mode = 1'b0; sel = 4'd5; y_ready = 1'b1;
        push_exp(8'h15, 4'd5, 1'b0, -1);
        apply_stimulus(1);
        sel = 4'd12;
        push_exp(8'h1C, 4'd12, 1'b0, 1);
        apply_stimulus(1);

        // Manual stall: held word survives a sel change.
        sel = 4'd5;
        push_exp(8'h15, 4'd5, 1'b0, -1);
        apply_stimulus(1);
        y_ready = 1'b0; sel = 4'd9;
        for (int i = 0; i < 4; i++) begin
            check_output("stall_data", 32'(y_data), 32'h15);
            check_output("stall_valid", 32'(y_valid), 32'd1);
            apply_stimulus(1);
        end
        y_ready = 1'b1;
        push_exp(8'h19, 4'd9, 1'b0, 1);
        apply_stimulus(1);

        // Scan with dwell 2 over channels 0, 1 and 4.
        mode = 1'b1; ch_en = 16'h0013; dwell = 8'd2;
        push_exp(8'h10, 4'd0, 1'b1, 1);
        push_exp(8'h11, 4'd1, 1'b0, 3);
        push_exp(8'h14, 4'd4, 1'b0, 3);
        push_exp(8'h10, 4'd0, 1'b1, 3);
        push_exp(8'h11, 4'd1, 1'b0, 3);
        apply_stimulus(13);

        // Dwell 0, then stall on the ch0 sample and check nothing is skipped.
        dwell = 8'd0;
        push_exp(8'h14, 4'd4, 1'b0, 3);
        push_exp(8'h10, 4'd0, 1'b1, -1);
        apply_stimulus(4);
        check_output("scan_stall_ch", 32'(y_ch), 32'd0);
        y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_output("scan_stall_data", 32'(y_data), 32'h10);
            apply_stimulus(1);
        end
        y_ready = 1'b1;
        push_exp(8'h11, 4'd1, 1'b0, 1);
        apply_stimulus(1);

        // Empty enable mask stops sampling; restore a single high channel.
        ch_en = 16'h0000;
        apply_stimulus(1);
        for (int i = 0; i < 4; i++) begin
            check_output("empty_mask_valid", 32'(y_valid), 32'd0);
            apply_stimulus(1);
        end
        ch_en = 16'h8000;
        push_exp(8'h1F, 4'd15, 1'b1, -1);
        push_exp(8'h1F, 4'd15, 1'b1, 1);
        push_exp(8'h1F, 4'd15, 1'b1, 1);
        apply_stimulus(4);

        // Asynchronous reset between edges discards the in-flight word.
        check_output("pre_reset_valid", 32'(y_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_rst_valid", 32'(y_valid), 32'd0);
        check_output("async_rst_data", 32'(y_data), 32'd0);
        check_output("async_rst_ch", 32'(y_ch), 32'd0);
        check_output("async_rst_wrap", 32'(scan_wrap), 32'd0);
        ch_en = 16'h0000;
        apply_stimulus(2);
        rst_n = 1'b1;
        apply_stimulus(2);
        check_output("post_rst_valid", 32'(y_valid), 32'd0);
        check_output("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
